blake_g_scheduler: RTL and testbench

//  Sequences the single shared G-function core of the BLAKE-512 compression engine.

---
 rtl/blake_g_scheduler.sv | 104 ++++++++++
 tb/tb_blake_g_scheduler.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/blake_g_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// blake_g_scheduler : sequences the shared G core of a BLAKE-512 compressor
// Rev 1.0
// ---------------------------------------------------------------------------
module blake_g_scheduler #(
  parameter int NUM_ROUNDS   = 16,
  parameter int G_PER_ROUND  = 8,
  parameter int SIGMA_PERIOD = 10,
  parameter int RW           = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_blk_valid,
  output logic          o_blk_ready,
  input  logic          i_blk_last,
  output logic          o_init_round,
  output logic          o_g_start,
  input  logic          i_g_done,
  output logic [2:0]    o_g_idx,
  output logic [RW-1:0] o_round_idx,
  output logic [3:0]    o_sigma_row,
  output logic          o_final_en,
  output logic          o_hash_valid,
  input  logic          i_hash_ready,
  output logic          o_busy
);

  localparam logic [2:0]    c_G_LAST     = 3'(G_PER_ROUND - 1);
  localparam logic [RW-1:0] c_ROUND_LAST = RW'(NUM_ROUNDS - 1);
  localparam logic [3:0]    c_SIGMA_LAST = 4'(SIGMA_PERIOD - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_INIT    = 3'd1,
    S_G_ISSUE = 3'd2,
    S_G_WAIT  = 3'd3,
    S_FINAL   = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t        r_state;
  logic [2:0]    r_g_idx;
  logic [RW-1:0] r_round_idx;
  logic [3:0]    r_sigma_row;
  logic          r_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_g_idx     <= '0;
      r_round_idx <= '0;
      r_sigma_row <= '0;
      r_last      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_blk_valid) begin
            r_last      <= i_blk_last;
            r_g_idx     <= '0;
            r_round_idx <= '0;
            r_sigma_row <= '0;
            r_state     <= S_INIT;
          end
        end
        S_INIT:    r_state <= S_G_ISSUE;
        S_G_ISSUE: r_state <= S_G_WAIT;
        S_G_WAIT: begin
          // g_done is only honoured here so early/spurious pulses cannot skip a step
          if (i_g_done) begin
            if (r_g_idx != c_G_LAST) begin
              r_g_idx <= r_g_idx + 3'd1;
              r_state <= S_G_ISSUE;
            end else if (r_round_idx != c_ROUND_LAST) begin
              r_g_idx     <= '0;
              r_round_idx <= r_round_idx + RW'(1);
              r_sigma_row <= (r_sigma_row == c_SIGMA_LAST) ? 4'd0 : r_sigma_row + 4'd1;
              r_state     <= S_G_ISSUE;
            end else begin
              r_state <= S_FINAL;
            end
          end
        end
        S_FINAL: r_state <= r_last ? S_DONE : S_IDLE;
        S_DONE: begin
          if (i_hash_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_blk_ready  = (r_state == S_IDLE);
  assign o_init_round = (r_state == S_INIT);
  assign o_g_start    = (r_state == S_G_ISSUE);
  assign o_final_en   = (r_state == S_FINAL);
  assign o_hash_valid = (r_state == S_DONE);
  assign o_busy       = (r_state != S_IDLE);
  assign o_g_idx      = r_g_idx;
  assign o_round_idx  = r_round_idx;
  assign o_sigma_row  = r_sigma_row;

endmodule
`default_nettype wire

// File: tb/tb_blake_g_scheduler.sv
`default_nettype none
`timescale 1ns/1ps
// Testbench for blake_g_scheduler: table-driven block runs with a G-index scoreboard.
module tb_blake_g_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i_blk_valid = 1'b0;
  logic       i_blk_last = 1'b0;
  logic       i_hash_ready = 1'b0;
  logic       core_done = 1'b0;
  logic       spur = 1'b0;
  logic       i_g_done;
  logic       o_blk_ready, o_init_round, o_g_start, o_final_en, o_hash_valid, o_busy;
  logic [2:0] o_g_idx;
  logic [3:0] o_round_idx;
  logic [3:0] o_sigma_row;

  assign i_g_done = core_done | spur;

  always #5 clk = ~clk;

  blake_g_scheduler #(.NUM_ROUNDS(16), .G_PER_ROUND(8), .SIGMA_PERIOD(10), .RW(4)) dut (
    .clk(clk), .rst(rst),
    .i_blk_valid(i_blk_valid), .o_blk_ready(o_blk_ready), .i_blk_last(i_blk_last),
    .o_init_round(o_init_round), .o_g_start(o_g_start), .i_g_done(i_g_done),
    .o_g_idx(o_g_idx), .o_round_idx(o_round_idx), .o_sigma_row(o_sigma_row),
    .o_final_en(o_final_en), .o_hash_valid(o_hash_valid), .i_hash_ready(i_hash_ready),
    .o_busy(o_busy)
  );

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s", name);
  endtask

  int cyc;
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  typedef struct { int r; int s; int g; } step_t;
  step_t q[$];

  int cur_L = 1;
  int init_cyc, init_cnt, gs_first, gs_cnt, final_cyc, fe_cnt, hv_cyc, prev_gs;

  task automatic clear_capture();
    init_cyc = -1; init_cnt = 0; gs_first = -1; gs_cnt = 0;
    final_cyc = -1; fe_cnt = 0; hv_cyc = -1; prev_gs = -1;
  endtask

  // G core model: g_done arrives cur_L cycles after each g_start
  initial begin
    int pending;
    pending = 0;
    forever begin
      @(negedge clk);
      core_done = 1'b0;
      if (rst) pending = 0;
      else if (pending > 0) begin
        pending--;
        if (pending == 0) core_done = 1'b1;
      end else if (o_g_start) pending = cur_L;
    end
  end

  // Monitor and scoreboard consumer
  initial begin
    step_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (o_init_round) begin
          if (init_cyc < 0) init_cyc = cyc;
          init_cnt++;
          prev_gs = -1;
        end
        if (o_g_start) begin
          if (gs_first < 0) gs_first = cyc;
          gs_cnt++;
          if (prev_gs >= 0) check("step_gap", 64'(cyc - prev_gs), 64'(cur_L + 1));
          prev_gs = cyc;
          if (q.size() == 0) fail_now("scoreboard_underflow");
          else begin
            e = q.pop_front();
            check("round_idx", 64'(o_round_idx), 64'(e.r));
            check("sigma_row", 64'(o_sigma_row), 64'(e.s));
            check("g_idx", 64'(o_g_idx), 64'(e.g));
            check("diag_bit", 64'(o_g_idx[2]), 64'(e.g >= 4));
          end
        end
        if (o_final_en) begin
          if (final_cyc < 0) final_cyc = cyc;
          fe_cnt++;
        end
        if (o_hash_valid && hv_cyc < 0) hv_cyc = cyc;
      end
    end
  end

  typedef struct {
    bit last; int lat; int hold; bit spurious; int start_at;
    int exp_final_off; bit exp_hv;
  } row_t;

  task automatic push_block();
    for (int r = 0; r < 16; r++)
      for (int g = 0; g < 8; g++)
        q.push_back('{r, r % 10, g});
  endtask

  task automatic run_block(input row_t rw);
    int t;
    int hs;
    cur_L = rw.lat;
    clear_capture();
    push_block();
    @(negedge clk);
    t = 0;
    while (rw.start_at >= 0 && cyc < rw.start_at && t < 200) begin @(negedge clk); t++; end
    i_blk_valid = 1'b1;
    i_blk_last  = rw.last;
    t = 0;
    while (!o_blk_ready && t < 50) begin @(negedge clk); t++; end
    if (!o_blk_ready) fail_now("handshake_timeout");
    hs = cyc;
    if (rw.start_at >= 0) check("hs_cycle", 64'(hs), 64'(rw.start_at));
    @(negedge clk);
    i_blk_valid = 1'b0;
    i_blk_last  = 1'b0;
    if (rw.spurious) begin
      spur = 1'b1;           // covers INIT and G_ISSUE cycles
      @(negedge clk);
      @(negedge clk);
      spur = 1'b0;
    end
    t = 0;
    while (!o_final_en && t < 130 * (rw.lat + 1) + 20) begin @(negedge clk); t++; end
    if (!o_final_en) fail_now("final_en_timeout");
    @(negedge clk);
    check("init_cycle", 64'(init_cyc), 64'(hs + 1));
    check("first_gstart", 64'(gs_first), 64'(hs + 2));
    check("gstart_count", 64'(gs_cnt), 64'd128);
    check("final_cycle", 64'(final_cyc), 64'(hs + rw.exp_final_off));
    check("final_count", 64'(fe_cnt), 64'd1);
    check("sb_empty", 64'(q.size()), 64'd0);
    if (rw.exp_hv) begin
      check("hv_in_done", 64'(o_hash_valid), 64'd1);
      i_blk_valid = 1'b1;
      for (int i = 0; i < rw.hold; i++) begin
        check("done_hold_hv", 64'(o_hash_valid), 64'd1);
        check("done_hold_ready", 64'(o_blk_ready), 64'd0);
        @(negedge clk);
      end
      i_hash_ready = 1'b1;
      i_blk_valid  = 1'b0;
      @(negedge clk);
      i_hash_ready = 1'b0;
      check("hv_cycle", 64'(hv_cyc), 64'(hs + rw.exp_final_off + 1));
      check("post_done_hv", 64'(o_hash_valid), 64'd0);
      check("post_done_ready", 64'(o_blk_ready), 64'd1);
      check("post_done_busy", 64'(o_busy), 64'd0);
      check("no_extra_accept", 64'(init_cnt), 64'd1);
    end else begin
      check("chain_ready", 64'(o_blk_ready), 64'd1);
      check("chain_hv", 64'(o_hash_valid), 64'd0);
      check("chain_busy", 64'(o_busy), 64'd0);
      repeat (3) @(negedge clk);
      check("chain_no_hv", 64'(hv_cyc), 64'hFFFF_FFFF_FFFF_FFFF);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_blk_ready"}, 64'(o_blk_ready), 64'd1);
    check({tag, "_busy"}, 64'(o_busy), 64'd0);
    check({tag, "_hash_valid"}, 64'(o_hash_valid), 64'd0);
    check({tag, "_init"}, 64'(o_init_round), 64'd0);
    check({tag, "_gstart"}, 64'(o_g_start), 64'd0);
    check({tag, "_final"}, 64'(o_final_en), 64'd0);
    check({tag, "_g_idx"}, 64'(o_g_idx), 64'd0);
    check({tag, "_round"}, 64'(o_round_idx), 64'd0);
    check({tag, "_sigma"}, 64'(o_sigma_row), 64'd0);
  endtask

  row_t rows[4];

  initial begin
    int t;
    // {last, L, hold, spurious, start_at, final offset, hash_valid expected}
    rows[0] = '{1'b1, 1, 20, 1'b0, 10, 258, 1'b1};
    rows[1] = '{1'b0, 2, 0,  1'b0, -1, 386, 1'b0};
    rows[2] = '{1'b1, 1, 0,  1'b0, -1, 258, 1'b1};
    rows[3] = '{1'b1, 5, 3,  1'b1, -1, 770, 1'b1};

    clear_capture();
    repeat (3) @(negedge clk);
    check_reset_vals("rst0");
    rst = 1'b0;

    for (int i = 0; i < 4; i++) run_block(rows[i]);

    // Abort mid-computation at round 5, step 3
    cur_L = 1;
    clear_capture();
    push_block();
    @(negedge clk);
    i_blk_valid = 1'b1;
    i_blk_last  = 1'b1;
    @(negedge clk);
    i_blk_valid = 1'b0;
    t = 0;
    while (!(o_g_start && o_round_idx == 4'd5 && o_g_idx == 3'd3) && t < 400) begin
      @(negedge clk); t++;
    end
    if (t >= 400) fail_now("abort_target_timeout");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_vals("abort");
    rst = 1'b0;
    q.delete();
    repeat (2) @(negedge clk);
    check("abort_no_final", 64'(fe_cnt), 64'd0);
    check("abort_idle_ready", 64'(o_blk_ready), 64'd1);
    check("abort_idle_hv", 64'(o_hash_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
